ad100_fetch: RTL and testbench
==============================

# ad100_fetch

Instruction fetch stage for the ad100 CPU. Sits between the instruction RAM port and the CPU decode stage that consumes `cpu.instruction`. It issues sequential word reads, buffers returned instructions in a small prefetch queue, and hands them to decode over a valid/ready handshake. It flushes and redirects on taken branches and jumps, and optionally flags the `jal x0,0` self-loop that marks program completion.

## Interface
- `DEPTH`, 4: prefetch queue entries (power of two, ≥2)
- `RESET_PC`, 32'h0000_0000: first fetch address after reset
- `clk  in  1  system clock; all state changes on rising edge`
- `reset  in  1  asynchronous, active-high reset`
- `mem_req  out  1  read request to instruction RAM this cycle`
- `mem_addr  out  32  byte address of request; bits [1:0] always 0`
- `mem_rdata  in  32  read data; valid exactly one cycle after mem_req (RAM never stalls)`
- `redirect  in  1  branch/jump taken; flush and refetch`
- `redirect_pc  in  32  new PC when redirect=1`
- `inst_valid  out  1  queue head holds an instruction`
- `inst_ready  in  1  decode accepts head this cycle`
- `instruction  out  32  head instruction; 32'h0000_0013 (nop) when empty`
- `inst_pc  out  32  PC of head instruction; 0 when empty`
- `halted  out  1  sticky self-loop detected (see Configuration)`

## Operation
- Registers: `fetch_pc`; `pending` (request issued last cycle); `count` (0..DEPTH); circular queue of {pc, instruction} with read/write pointers modulo DEPTH.
- Request rule: `mem_req = !redirect && (count + pending) < DEPTH`. `mem_addr = fetch_pc`. On an issued request, `fetch_pc <= fetch_pc + 4` (wraps modulo 2^32) and `pending <= 1`.
- Response: when `pending=1` and no redirect this cycle, push {pc_of_request, mem_rdata} at the edge. The request rule guarantees space, so no push is ever dropped.
- Pop: `inst_valid && inst_ready` advances the read pointer. Simultaneous push and pop leaves `count` unchanged, including when `count=DEPTH`.
- Redirect (has priority over everything):
  - Queue is cleared (`count<=0`, pointers reset).
  - In-flight response is discarded (`pending<=0`).
  - `fetch_pc <= {redirect_pc[31:2],2'b00}`. Misaligned low bits are silently cleared.
  - A pop in the same cycle is still counted as accepted by decode.
- The head outputs are combinational from queue storage and `count`. No bubble is inserted between consecutive entries.

## Timing
- Reset (async assert) values: `mem_req=0`, `mem_addr=RESET_PC`, `inst_valid=0`, `instruction=32'h13`, `inst_pc=0`, `halted=0`, `count=0`, `pending=0`.
- Cycle 0 = first edge after reset deasserts:
  - `mem_req=1`, addr `RESET_PC` during cycle 0.
  - Data returned in cycle 1 and pushed at the end of cycle 1.
  - `inst_valid=1` in cycle 2.
- Steady state with `inst_ready=1`: one instruction per cycle.
- Redirect asserted in cycle N:
  - `mem_req=0` in N; `inst_valid=0` in N+1.
  - Request to the new PC in N+1; instruction valid in N+3 (3-cycle penalty).
- With `inst_ready=0`: the queue fills to DEPTH and `mem_req` stays low until a pop frees space.
  - A pop in cycle N lets `mem_req` rise in N+1.

## Configuration
- `AD100_FETCH_HALT_DETECT_EN` defined:
  - `halted` sets at the edge where a head instruction equal to 32'h0000_006f (`jal x0,0`) is popped.
  - It then stays 1 until reset; redirect does not clear it.
  - Fetching continues normally.
- Not defined: `halted` is constant 0 and no comparator is built.

## Test plan
- Reset, RAM[i]=i+1, `inst_ready=1` → `inst_valid` first high in cycle 2 with instruction 1, pc 0. Then instructions 2, 3, 4 with pc 4, 8, 12 on consecutive cycles.
- Hold `inst_ready=0` for 10 cycles → exactly 4 requests issued and `count=4`, with `mem_req=0` thereafter. Release → 4 entries drained in order with no loss or duplication, and requests resume one cycle after the first pop.
- Redirect to 32'h0000_0103 with full queue and a pending response → `inst_valid=0` next cycle and `mem_addr=32'h100` the cycle after. First instruction delivered is RAM[0x40] with pc 0x100, and the stale response never appears.
- `fetch_pc` at 32'hFFFF_FFFC, streaming → next request address is 32'h0000_0000.
- Macro defined, RAM[2]=32'h0000_006f, redirect to 8 after each pop of it → `halted` rises on the first pop, stays 1, and `instruction` is constant 32'h6f after that. Macro undefined: same stimulus → `halted` stays 0.
- Assert `reset` mid-stream (not on a clock edge) → all outputs return to reset values immediately, and fetch restarts at `RESET_PC` after release.

Source files
------------

// File: rtl/ad100_fetch.sv
// ad100_fetch: instruction fetch stage for the ad100 CPU.
// It issues sequential word reads to a fixed one-cycle-latency instruction RAM.
// Returned words are buffered in a DEPTH-entry prefetch queue. The queue head is
// presented to decode over a valid/ready handshake.
// A taken branch or jump (redirect) flushes the queue, drops the in-flight
// response and restarts fetch at the new word-aligned PC.
// Optional feature: define AD100_FETCH_HALT_DETECT_EN to build the sticky
// detector for the `jal x0,0` self-loop that marks program completion.
// Without that macro, halted is tied low.
module ad100_fetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    output logic        halted
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [31:0]   NOP_INST  = 32'h0000_0013;
    localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic          pending;
    logic          running;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   q_pc   [DEPTH];
    logic [31:0]   q_inst [DEPTH];

    logic          push;
    logic          pop;
    logic [CW:0]   occupancy;

    // Request gating and head presentation.
    // Requests are held off until the first edge after reset, so mem_req stays low
    // while reset is asserted. A request is made only when the queue is guaranteed
    // to have room for its response.
    always_comb begin
        occupancy   = {1'b0, count} + {{CW{1'b0}}, pending};
        mem_req     = running && !redirect && (occupancy < DEPTH_OCC);
        mem_addr    = fetch_pc;
        push        = pending && !redirect;
        inst_valid  = (count != '0);
        pop         = inst_valid && inst_ready;
        instruction = NOP_INST;
        inst_pc     = 32'h0000_0000;
        if (inst_valid) begin
            instruction = q_inst[rd_ptr];
            inst_pc     = q_pc[rd_ptr];
        end
    end

    // Fetch PC, outstanding-request tracking and queue occupancy.
    // Redirect overrides every other update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running  <= 1'b0;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            pending  <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            running <= 1'b1;
            if (redirect) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                pending  <= 1'b0;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                pending <= mem_req;
                if (mem_req) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    req_pc   <= fetch_pc;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    // Queue storage.
    // Each returned word is written together with the PC it was fetched from.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]   <= req_pc;
            q_inst[wr_ptr] <= mem_rdata;
        end
    end

`ifdef AD100_FETCH_HALT_DETECT_EN
    // Sticky completion flag.
    // It sets when decode accepts a `jal x0,0`, including during a redirect cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted <= 1'b0;
        end else if (pop && (instruction == 32'h0000_006f)) begin
            halted <= 1'b1;
        end
    end
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_ad100_fetch.sv
// tb_ad100_fetch: self-checking bench for ad100_fetch.
// The RAM model returns ram[addr[9:2]] one cycle after a request, with
// ram[i] = i+1 unless a test overrides an entry.
module tb_ad100_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ram [256];

`ifdef AD100_FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    typedef struct {
        logic        ready;
        logic        redir;
        logic [31:0] redir_pc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [12];

    ad100_fetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .instruction (instruction),
        .inst_pc     (inst_pc),
        .halted      (halted)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Instruction RAM: data is returned the cycle after the request.
    always @(posedge clk) begin
        if (mem_req) begin
            mem_rdata <= ram[mem_addr[9:2]];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance into the next cycle, leaving time before inputs are driven.
    task automatic startCycle;
        @(posedge clk);
        #1;
    endtask

    // Assert reset and check the reset values.
    // On return, the next rising edge is cycle-0 edge.
    task automatic applyReset;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_mem_req", {31'b0, mem_req}, 32'h0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_valid", {31'b0, inst_valid}, 32'h0);
        checkOutput("rst_inst", instruction, 32'h13);
        checkOutput("rst_pc", inst_pc, 32'h0);
        checkOutput("rst_halted", {31'b0, halted}, 32'h0);
        #1;
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            startCycle();
            inst_ready  = vecs[i].ready;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].redir_pc;
            #1;
            checkOutput($sformatf("vec%0d_req", i), {31'b0, mem_req}, {31'b0, vecs[i].exp_req});
            checkOutput($sformatf("vec%0d_addr", i), mem_addr, vecs[i].exp_addr);
            checkOutput($sformatf("vec%0d_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].exp_valid});
            checkOutput($sformatf("vec%0d_inst", i), instruction, vecs[i].exp_inst);
            checkOutput($sformatf("vec%0d_pc", i), inst_pc, vecs[i].exp_pc);
        end
        redirect = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic        prev_redir;
        logic        seen;
        int          req_count;
        int          got;
        bit          done;

        for (int i = 0; i < 256; i++) ram[i] = 32'(i + 1);

        // Columns: ready, redir, redir_pc, exp_req, exp_addr, exp_valid, exp_inst, exp_pc.
        vecs[0]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h13,  32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         1'b0, 32'h13,  32'h0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         1'b1, 32'h1,   32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hC,         1'b1, 32'h2,   32'h4};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h10,        1'b1, 32'h3,   32'h8};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h14,        1'b1, 32'h4,   32'hC};
        vecs[6]  = '{1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h18,        1'b1, 32'h5,   32'h10};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'h13,  32'h0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h13,  32'h0};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'h100, 32'hFFFF_FFFC};
        vecs[10] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         1'b1, 32'h1,   32'h0};
        vecs[11] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hC,         1'b1, 32'h2,   32'h4};

        // Streaming startup, misaligned redirect and address wrap.
        applyReset();
        applyStimulus(0, 11);

        // Stall with inst_ready low, then drain.
        applyReset();
        req_count = 0;
        for (int c = 0; c < 10; c++) begin
            startCycle();
            inst_ready = 1'b0;
            #1;
            if (mem_req) req_count++;
        end
        checkOutput("stall_req_count", 32'(req_count), 32'd4);
        checkOutput("stall_req_low", {31'b0, mem_req}, 32'h0);
        checkOutput("stall_head", instruction, 32'h1);
        for (int k = 0; k < 5; k++) begin
            startCycle();
            inst_ready = 1'b1;
            #1;
            if (k == 0) checkOutput("drain_req_first", {31'b0, mem_req}, 32'h0);
            if (k == 1) begin
                checkOutput("drain_req_resume", {31'b0, mem_req}, 32'h1);
                checkOutput("drain_addr_resume", mem_addr, 32'h10);
            end
            checkOutput($sformatf("drain%0d_valid", k), {31'b0, inst_valid}, 32'h1);
            checkOutput($sformatf("drain%0d_inst", k), instruction, 32'(k + 1));
            checkOutput($sformatf("drain%0d_pc", k), inst_pc, 32'(4 * k));
        end

        // Redirect with a busy queue and a response in flight.
        applyReset();
        for (int c = 0; c < 4; c++) begin
            startCycle();
            inst_ready = 1'b0;
        end
        startCycle();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        #1;
        checkOutput("redir_req_low", {31'b0, mem_req}, 32'h0);
        startCycle();
        redirect   = 1'b0;
        inst_ready = 1'b1;
        #1;
        checkOutput("redir_valid_n1", {31'b0, inst_valid}, 32'h0);
        checkOutput("redir_req_n1", {31'b0, mem_req}, 32'h1);
        checkOutput("redir_addr_n1", mem_addr, 32'h100);
        startCycle();
        #1;
        checkOutput("redir_valid_n2", {31'b0, inst_valid}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            startCycle();
            #1;
            checkOutput($sformatf("redir_stream%0d_inst", k), instruction, 32'h41 + 32'(k));
            checkOutput($sformatf("redir_stream%0d_pc", k), inst_pc, 32'h100 + 32'(4 * k));
        end

        // Self-loop completion marker.
        ram[2] = 32'h0000_006f;
        applyReset();
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            startCycle();
            inst_ready  = 1'b1;
            redirect    = inst_valid && (instruction == 32'h0000_006f);
            redirect_pc = 32'h8;
            #1;
            checkOutput($sformatf("halt_c%0d", c), {31'b0, halted}, {31'b0, seen && HALT_EN});
            if (seen && inst_valid) checkOutput($sformatf("halt_inst_c%0d", c), instruction, 32'h6f);
            if (redirect) seen = 1'b1;
        end
        redirect = 1'b0;
        checkOutput("halt_seen", {31'b0, seen}, 32'h1);
        ram[2] = 32'h3;

        // Asynchronous reset mid-stream, then restart from RESET_PC.
        applyReset();
        for (int c = 0; c < 5; c++) begin
            startCycle();
            inst_ready = 1'b1;
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_req", {31'b0, mem_req}, 32'h0);
        checkOutput("mid_rst_addr", mem_addr, 32'h0);
        checkOutput("mid_rst_valid", {31'b0, inst_valid}, 32'h0);
        checkOutput("mid_rst_inst", instruction, 32'h13);
        checkOutput("mid_rst_pc", inst_pc, 32'h0);
        checkOutput("mid_rst_halted", {31'b0, halted}, 32'h0);
        applyReset();
        applyStimulus(0, 5);

        // Random traffic against an in-order stream model.
        // Each accepted instruction must be the word at the expected PC.
        // A redirect restarts the expected stream at the aligned target.
        applyReset();
        exp_pc     = 32'h0;
        prev_redir = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            startCycle();
            inst_ready  = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom();
            #1;
            if (prev_redir) checkOutput("rnd_valid_after_redir", {31'b0, inst_valid}, 32'h0);
            if (redirect) checkOutput("rnd_req_on_redir", {31'b0, mem_req}, 32'h0);
            if (inst_valid && inst_ready) begin
                checkOutput("rnd_pc", inst_pc, exp_pc);
                checkOutput("rnd_inst", instruction, ram[exp_pc[9:2]]);
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
            prev_redir = redirect;
        end

        // The stream must keep flowing once redirects stop.
        redirect = 1'b0;
        got  = 0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            startCycle();
            inst_ready = 1'b1;
            #1;
            if (inst_valid) begin
                checkOutput("tail_pc", inst_pc, exp_pc);
                checkOutput("tail_inst", instruction, ram[exp_pc[9:2]]);
                exp_pc = exp_pc + 32'd4;
                got++;
                if (got == 4) done = 1'b1;
            end
        end
        checkOutput("tail_delivered", 32'(got), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
